// File: rtl/fft_host_sequencer.sv
// Host-side initiator for the 1D FFT unit: buffers N samples, issues reset/start,
// loads the samples, waits for the done code, captures the results and drains them.
module fft_host_sequencer #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    LOG_N      = 3,
    parameter int                    SEQ_W      = 4,
    parameter int                    AGU_MODE_W = 3,
    parameter logic [AGU_MODE_W:0]   DONE_CODE  = 4'b1111,
    parameter int                    RD_LAT     = 2,
    parameter int                    TIMEOUT    = 4096
) (
    input  logic                              i_fft_base_clock,
    input  logic                              i_fft_reset,
    input  logic                              i_go,
    input  logic [SEQ_W-1:0]                  i_sequence,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [DATA_WIDTH-1:0]             s_data,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [DATA_WIDTH-1:0]             m_data,
    output logic [SEQ_W+1:0]                  o_command,
    input  logic [LOG_N+2+AGU_MODE_W:0]       i_status,
    output logic [DATA_WIDTH-1:0]             o_data,
    output logic                              o_data_oe,
    input  logic [DATA_WIDTH-1:0]             i_data,
    output logic                              o_busy,
    output logic                              o_done,
    output logic                              o_error
);

    localparam int N        = 2 ** LOG_N;
    localparam int STATUS_W = LOG_N + 2 + AGU_MODE_W + 1;
    localparam int K_W      = LOG_N + 1;
    localparam int WAIT_W   = $clog2(TIMEOUT + 1);
    localparam int LAT_W    = $clog2(RD_LAT + 1);
    localparam int CNT_W    = (LAT_W < 1) ? 1 : LAT_W;

    localparam logic [K_W-1:0]    K_LAST    = K_W'(N - 1);
    localparam logic [K_W-1:0]    K_FULL    = K_W'(N);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  LAT_LAST  = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0]  RST_LAST  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_RST,
        S_START,
        S_LOAD,
        S_WAIT_DONE,
        S_CAPTURE,
        S_DRAIN
    } state_t;

    state_t                state;
    logic [SEQ_W-1:0]      seq;
    logic [K_W-1:0]        k;
    logic [CNT_W-1:0]      cnt;
    logic [WAIT_W-1:0]     wait_cnt;

    logic [DATA_WIDTH-1:0] sample_mem [N];
    logic                  mem_we;
    logic [LOG_N-1:0]      mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  done_seen;

    assign done_seen = (i_status[STATUS_W-1 -: AGU_MODE_W+1] == DONE_CODE);

    // One write port shared by the FILL path (upstream samples) and the CAPTURE path (results).
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
        mem_we    = 1'b0;
        mem_waddr = k[LOG_N-1:0];
        mem_wdata = s_data;
        if (state == S_FILL && s_valid && s_ready) begin
            mem_we = 1'b1;
        end else if (state == S_CAPTURE && cnt == LAT_LAST) begin
            mem_we    = 1'b1;
            mem_wdata = i_data;
        end
    end

    // NOTE: the sample buffer is deliberately not reset; its contents are rewritten before every use.
    always_ff @(posedge i_fft_base_clock) begin
        if (mem_we) begin
            sample_mem[mem_waddr] <= mem_wdata;
        end
    end

    // NOTE: all state and registered outputs use non-blocking assignments so every update lands on the same edge.
    always_ff @(posedge i_fft_base_clock) begin
        if (i_fft_reset) begin
            state     <= S_IDLE;
            seq       <= '0;
            k         <= '0;
            cnt       <= '0;
            wait_cnt  <= '0;
            s_ready   <= 1'b0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            o_command <= '0;
            o_data    <= '0;
            o_data_oe <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_error   <= 1'b0;
        end else begin
            o_done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (i_go) begin
                        seq     <= i_sequence;
                        o_error <= 1'b0;
                        k       <= '0;
                        s_ready <= 1'b1;
                        o_busy  <= 1'b1;
                        state   <= S_FILL;
                    end
                end

                S_FILL: begin
                    if (s_valid && s_ready) begin
                        if (k == K_LAST) begin
                            k         <= '0;
                            s_ready   <= 1'b0;
                            cnt       <= '0;
                            o_command <= {2'b10, seq};
                            state     <= S_RST;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end

                S_RST: begin
                    if (cnt == RST_LAST) begin
                        o_command <= {2'b01, seq};
                        state     <= S_START;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                // Preload the first sample so the bus carries data on the very first LOAD cycle.
                S_START: begin
                    o_command <= {2'b00, seq};
                    o_data_oe <= 1'b1;
                    o_data    <= sample_mem[0];
                    k         <= K_W'(1);
                    state     <= S_LOAD;
                end

                S_LOAD: begin
                    if (k == K_FULL) begin
                        o_data_oe <= 1'b0;
                        o_data    <= '0;
                        k         <= '0;
                        wait_cnt  <= '0;
                        state     <= S_WAIT_DONE;
                    end else begin
                        o_data <= sample_mem[k[LOG_N-1:0]];
                        k      <= k + 1'b1;
                    end
                end

                // The done code takes priority over a timeout in the same cycle.
                S_WAIT_DONE: begin
                    if (done_seen) begin
                        cnt   <= '0;
                        k     <= '0;
                        state <= S_CAPTURE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        o_error   <= 1'b1;
                        o_command <= '0;
                        o_busy    <= 1'b0;
                        wait_cnt  <= '0;
                        state     <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                S_CAPTURE: begin
                    if (cnt != LAT_LAST) begin
                        cnt <= cnt + 1'b1;
                    end else if (k == K_LAST) begin
                        k       <= '0;
                        m_valid <= 1'b1;
                        m_data  <= (k == '0) ? i_data : sample_mem[0];
                        state   <= S_DRAIN;
                    end else begin
                        k <= k + 1'b1;
                    end
                end

                S_DRAIN: begin
                    if (m_ready) begin
                        if (k == K_LAST) begin
                            k         <= '0;
                            m_valid   <= 1'b0;
                            m_data    <= '0;
                            o_done    <= 1'b1;
                            o_busy    <= 1'b0;
                            o_command <= '0;
                            state     <= S_IDLE;
                        end else begin
                            k      <= k + 1'b1;
                            m_data <= sample_mem[k[LOG_N-1:0] + 1'b1];
                        end
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_host_sequencer.sv
// Directed bench for fft_host_sequencer: load path, round trip, backpressure,
// timeout, reset mid-LOAD and ignored i_go, with hand-computed expectations.
module tb_fft_host_sequencer;

    localparam int DW    = 16;
    localparam int LOG_N = 3;
    localparam int N     = 8;
    localparam int SEQ_W = 4;
    localparam int AGU   = 3;
    localparam int SW    = LOG_N + 2 + AGU + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_go = 1'b0;
    logic [SEQ_W-1:0]  i_sequence = '0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [DW-1:0]     s_data = '0;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic [DW-1:0]     m_data;
    logic [SEQ_W+1:0]  o_command;
    logic [SW-1:0]     i_status = '0;
    logic [DW-1:0]     o_data;
    logic              o_data_oe;
    logic [DW-1:0]     i_data = '0;
    logic              o_busy;
    logic              o_done;
    logic              o_error;

    int total = 0;
    int bad   = 0;

    fft_host_sequencer #(
        .DATA_WIDTH(DW), .LOG_N(LOG_N), .SEQ_W(SEQ_W), .AGU_MODE_W(AGU),
        .DONE_CODE(4'b1111), .RD_LAT(2), .TIMEOUT(16)
    ) dut (
        .i_fft_base_clock(clk), .i_fft_reset(rst), .i_go(i_go), .i_sequence(i_sequence),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .o_command(o_command), .i_status(i_status),
        .o_data(o_data), .o_data_oe(o_data_oe), .i_data(i_data),
        .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [SEQ_W-1:0] seq);
        i_go = 1'b1;
        i_sequence = seq;
        tick();
        i_go = 1'b0;
        i_sequence = '0;
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL go_s_ready: got %b want 1", s_ready); end
        total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL go_busy: got %b want 1", o_busy); end
        total++; if (o_command !== 6'h00) begin bad++; $display("FAIL go_command: got %h want 00", o_command); end
    endtask

    task automatic fill(input logic [DW-1:0] base, input bit toggle);
        int n = 0;
        int cyc = 0;
        while (n < N && cyc < 40) begin
            s_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
            s_data  = s_valid ? base + DW'(n) : 16'hDEAD;
            total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL fill_ready n=%0d: got %b want 1", n, s_ready); end
            tick();
            if (s_valid) n++;
            cyc++;
        end
        s_valid = 1'b0;
        s_data  = '0;
        total++; if (n != N) begin bad++; $display("FAIL fill_count: got %0d want %0d", n, N); end
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL fill_ready_drop: got %b want 0", s_ready); end
    endtask

    // Entered in the first RST cycle; returns in the first WAIT_DONE cycle.
    task automatic load_check(input logic [SEQ_W-1:0] seq, input logic [DW-1:0] base);
        total++; if (o_command !== {2'b10, seq}) begin bad++; $display("FAIL rst_cmd1: got %b want %b", o_command, {2'b10, seq}); end
        tick();
        total++; if (o_command !== {2'b10, seq}) begin bad++; $display("FAIL rst_cmd2: got %b want %b", o_command, {2'b10, seq}); end
        tick();
        total++; if (o_command !== {2'b01, seq}) begin bad++; $display("FAIL start_cmd: got %b want %b", o_command, {2'b01, seq}); end
        total++; if (o_data_oe !== 1'b0) begin bad++; $display("FAIL start_oe: got %b want 0", o_data_oe); end
        tick();
        for (int i = 0; i < N; i++) begin
            total++; if (o_data_oe !== 1'b1) begin bad++; $display("FAIL load_oe i=%0d: got %b want 1", i, o_data_oe); end
            total++; if (o_data !== base + DW'(i)) begin bad++; $display("FAIL load_data i=%0d: got %h want %h", i, o_data, base + DW'(i)); end
            total++; if (o_command !== {2'b00, seq}) begin bad++; $display("FAIL load_cmd i=%0d: got %b want %b", i, o_command, {2'b00, seq}); end
            tick();
        end
        total++; if (o_data_oe !== 1'b0) begin bad++; $display("FAIL wait_oe: got %b want 0", o_data_oe); end
        total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL wait_busy: got %b want 1", o_busy); end
    endtask

    // Done code in the current cycle, results on i_data from two cycles later.
    task automatic capture(input logic [DW-1:0] out_base);
        i_status = {4'b1111, 5'b0};
        tick();
        i_status = '0;
        tick();
        for (int i = 0; i < N; i++) begin
            i_data = out_base + DW'(i);
            tick();
        end
        i_data = '0;
    endtask

    task automatic drain(input logic [DW-1:0] out_base, input bit toggle, input logic [SEQ_W-1:0] seq);
        int n = 0;
        int cyc = 0;
        while (n < N && cyc < 40) begin
            m_ready = toggle ? ((cyc % 2) == 1) : 1'b1;
            total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL drain_valid n=%0d: got %b want 1", n, m_valid); end
            total++; if (m_data !== out_base + DW'(n)) begin bad++; $display("FAIL drain_data n=%0d: got %h want %h", n, m_data, out_base + DW'(n)); end
            total++; if (o_command !== {2'b00, seq}) begin bad++; $display("FAIL drain_cmd: got %b want %b", o_command, {2'b00, seq}); end
            total++; if (o_done !== 1'b0) begin bad++; $display("FAIL drain_done_early: got %b want 0", o_done); end
            tick();
            if (m_ready) n++;
            cyc++;
        end
        m_ready = 1'b0;
        total++; if (n != N) begin bad++; $display("FAIL drain_count: got %0d want %0d", n, N); end
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL drain_end_valid: got %b want 0", m_valid); end
        total++; if (o_done !== 1'b1) begin bad++; $display("FAIL drain_done: got %b want 1", o_done); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL drain_busy: got %b want 0", o_busy); end
        total++; if (o_command !== 6'h00) begin bad++; $display("FAIL idle_cmd: got %b want 0", o_command); end
        tick();
        total++; if (o_done !== 1'b0) begin bad++; $display("FAIL done_pulse: got %b want 0", o_done); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL rst_s_ready: got %b want 0", s_ready); end
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
        total++; if (m_data !== 16'h0) begin bad++; $display("FAIL rst_m_data: got %h want 0", m_data); end
        total++; if (o_command !== 6'h00) begin bad++; $display("FAIL rst_command: got %b want 0", o_command); end
        total++; if (o_data !== 16'h0) begin bad++; $display("FAIL rst_o_data: got %h want 0", o_data); end
        total++; if (o_data_oe !== 1'b0) begin bad++; $display("FAIL rst_oe: got %b want 0", o_data_oe); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", o_busy); end
        total++; if (o_done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", o_done); end
        total++; if (o_error !== 1'b0) begin bad++; $display("FAIL rst_error: got %b want 0", o_error); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_load();
        go(4'h5);
        fill(16'h0001, 1'b0);
        load_check(4'h5, 16'h0001);
    endtask

    task automatic test_round_trip();
        capture(16'h0100);
        drain(16'h0100, 1'b0, 4'h5);
    endtask

    task automatic test_ignored_go();
        go(4'hA);
        fill(16'h0020, 1'b0);
        load_check(4'hA, 16'h0020);
        i_go = 1'b1;
        i_sequence = 4'h3;
        tick();
        i_go = 1'b0;
        i_sequence = '0;
        total++; if (o_command !== 6'b00_1010) begin bad++; $display("FAIL ign_cmd: got %b want 001010", o_command); end
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL ign_s_ready: got %b want 0", s_ready); end
        total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL ign_busy: got %b want 1", o_busy); end
        tick();
        capture(16'h0A00);
        drain(16'h0A00, 1'b0, 4'hA);
    endtask

    task automatic test_timeout();
        go(4'h7);
        fill(16'h0030, 1'b0);
        load_check(4'h7, 16'h0030);
        repeat (15) tick();
        total++; if (o_error !== 1'b0) begin bad++; $display("FAIL to_early: got %b want 0", o_error); end
        total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL to_busy_early: got %b want 1", o_busy); end
        tick();
        total++; if (o_error !== 1'b1) begin bad++; $display("FAIL to_error: got %b want 1", o_error); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL to_busy: got %b want 0", o_busy); end
        total++; if (o_command !== 6'h00) begin bad++; $display("FAIL to_cmd: got %b want 0", o_command); end
        tick();
        total++; if (o_error !== 1'b1) begin bad++; $display("FAIL to_sticky: got %b want 1", o_error); end
        go(4'h9);
        total++; if (o_error !== 1'b0) begin bad++; $display("FAIL to_clear: got %b want 0", o_error); end
    endtask

    // Continues the run started by test_timeout's final i_go.
    task automatic test_reset_mid_load();
        fill(16'h0040, 1'b0);
        repeat (5) tick();
        total++; if (o_data !== 16'h0042) begin bad++; $display("FAIL rml_load3: got %h want 0042", o_data); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (o_data_oe !== 1'b0) begin bad++; $display("FAIL rml_oe: got %b want 0", o_data_oe); end
        total++; if (o_command !== 6'h00) begin bad++; $display("FAIL rml_cmd: got %b want 0", o_command); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rml_busy: got %b want 0", o_busy); end
        tick();
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL rml_idle: got %b want 0", o_busy); end
    endtask

    task automatic test_back_to_back();
        go(4'h3);
        fill(16'h0011, 1'b1);
        load_check(4'h3, 16'h0011);
        capture(16'h0300);
        drain(16'h0300, 1'b1, 4'h3);
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_round_trip();
        test_ignored_go();
        test_timeout();
        test_reset_mid_load();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
